ram32_fifo_ctrl: RTL
====================

Name: ram32_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives a WIDTH-wide bank of 32x1 single-port distributed RAM primitives (X_RAM32), sitting directly upstream of the bank.
- The bank has one shared address bus, a level-sensitive WE and an asynchronous read, so the controller serialises writes and reads through a small state machine.
- The controller guarantees RAM_ADR and RAM_I never change while RAM_WE is high.
- It presents valid/ready streams on both sides.

Parameters:
- WIDTH, 8, data width; equals the number of 32x1 RAM instances in the bank.
- DEPTH, 32, fixed; AW = 5 address bits. Not overridable.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- IN_DATA  in  WIDTH  write data
- IN_VALID  in  1  write request
- IN_READY  out  1  write accepted on this edge when IN_VALID && IN_READY
- OUT_DATA  out  WIDTH  head-of-FIFO data
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  consumer takes OUT_DATA when OUT_VALID && OUT_READY
- RAM_ADR  out  5  bank address {ADR4..ADR0}
- RAM_I  out  WIDTH  bank write data
- RAM_WE  out  1  bank write enable
- RAM_O  in  WIDTH  bank asynchronous read data
- COUNT  out  6  entries held in RAM, 0..32; excludes the output register
- FULL  out  1  COUNT==32
- EMPTY  out  1  COUNT==0 && !OUT_VALID

Behaviour:
- Reset (async, immediate)
  - State=IDLE; wptr=rptr=0; COUNT=0; OUT_VALID=0; OUT_DATA=0.
  - RAM_WE=0, RAM_ADR=0, RAM_I=0; IN_READY=0 while reset is asserted.
  - RAM contents are not cleared.
- RAM_ADR, RAM_I and RAM_WE are flops loaded on the same edge as the state transition. No combinational path to the RAM pins.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, READ.
- IDLE arbitration, evaluated each cycle; read has priority:
  - If !OUT_VALID && COUNT>0: go to READ. RAM_ADR<=rptr. IN_READY=0.
  - Else if COUNT<32: IN_READY=1. On IN_VALID, latch IN_DATA into RAM_I, set RAM_ADR<=wptr, go to WR_SETUP.
  - Else: stay in IDLE, IN_READY=0.
- IN_READY is high only in IDLE under the condition above; it is 0 in all other states.
- Write sequence:
  - WR_SETUP: RAM_WE=0.
  - WR_PULSE: RAM_WE=1, exactly one cycle.
  - WR_HOLD: RAM_WE=0. On exit, wptr<=wptr+1 (mod 32), COUNT<=COUNT+1. Return to IDLE.
  - RAM_ADR and RAM_I are constant from the WR_SETUP edge through the WR_HOLD exit edge.
- READ: one cycle. On exit, OUT_DATA<=RAM_O, OUT_VALID<=1, rptr<=rptr+1 (mod 32), COUNT<=COUNT-1, return to IDLE.
- OUT_VALID clears on the edge where OUT_VALID && OUT_READY. OUT_DATA holds its value while OUT_READY=0.
- COUNT never increments and decrements on the same edge, since write and read occupy disjoint states.
- Pointers wrap 31->0. No separate wrap bit is needed; COUNT disambiguates full from empty.
- Latency: IN accepted at edge E0 into an empty FIFO gives OUT_VALID=1 after edge E5.
- Throughput: one write per 4 cycles (IDLE + 3 write states); one read per 2 cycles.
- Full: IN_READY=0; IN_DATA is ignored and the upstream stream is never dropped.
- Empty RAM with OUT_VALID=1: the controller serves writes only.
- Reset mid-write (any WR_* state): RAM_WE drops immediately and the partial entry is not counted.
- Illegal state encoding: return to IDLE with RAM_WE=0.

Decomposition:
- Package ram32_fifo_pkg:
  - state enum (5 states, one-hot encoded)
  - constants DEPTH=32, AW=5, CW=6
- No RTL sub-module inside the controller.
- Bench-only wrapper ram32_bank: WIDTH x X_RAM32 with a shared address bus and WE; it connects to the RAM_* ports.

Test Plan:
- Reset with RST_N low -> all outputs 0, IN_READY=0. Release reset with IN_VALID=1, IN_DATA=8'hA5 -> IN_READY=1 on the first IDLE cycle; OUT_VALID=1, OUT_DATA=8'hA5 exactly 5 edges after acceptance.
- Hold OUT_READY=0 and push 8'h00..8'h20 -> 33 accepted (32 in RAM + 1 in output register), COUNT=32, FULL=1, IN_READY=0. Drain -> values emerge in order 00..20, EMPTY=1 at the end.
- Wrap test: 40 writes interleaved with reads, OUT_READY toggling in a 1,0,0 pattern -> pointers wrap, data order preserved, COUNT never exceeds 32 or underflows.
- Bus-stability checker over all tests -> RAM_ADR/RAM_I never change while RAM_WE=1; RAM_WE is never high for more than 1 cycle.
- Pull RST_N low during WR_PULSE (COUNT=3) -> RAM_WE=0 within the same cycle; after release COUNT=0, EMPTY=1, OUT_VALID=0.
- OUT_VALID=1, OUT_READY=0 for 10 cycles, IN_VALID=1 -> OUT_DATA stable; writes continue at 1 per 4 cycles; no READ state entered until the output register is consumed.

Source files
------------

// File: rtl/ram32_fifo_pkg.sv
// ram32_fifo_pkg: shared constants and FSM state encoding for the 32-entry RAM FIFO controller
package ram32_fifo_pkg;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int CW = 6;
  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    WR_SETUP = 5'b00010,
    WR_PULSE = 5'b00100,
    WR_HOLD  = 5'b01000,
    READ     = 5'b10000
  } state_e;
endpackage

// File: rtl/ram32_fifo_ctrl.sv
// ram32_fifo_ctrl: FIFO controller serialising writes and reads onto a shared-address 32xWIDTH distributed RAM bank
module ram32_fifo_ctrl
  import ram32_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [AW-1:0]    RAM_ADR,
  output logic [WIDTH-1:0] RAM_I,
  output logic             RAM_WE,
  input  logic [WIDTH-1:0] RAM_O,
  output logic [CW-1:0]    COUNT,
  output logic             FULL,
  output logic             EMPTY
);
  state_e state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, adr_q, adr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] di_q, di_d, out_data_q, out_data_d;
  logic we_q, we_d, out_valid_q, out_valid_d;
  logic rd_go, wr_ok;
  // Next-state logic: reads win arbitration in IDLE; RAM bus values change only when a new access starts
  always_comb begin
    rd_go = state_q == IDLE && !out_valid_q && count_q != '0;
    wr_ok = state_q == IDLE && !rd_go && count_q != CW'(DEPTH);
    IN_READY = RST_N && wr_ok;
    state_d = state_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    adr_d = adr_q;
    di_d = di_q;
    we_d = 1'b0;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q && !OUT_READY;
    case (state_q)
      IDLE: begin
        if (rd_go) begin
          state_d = READ;
          adr_d = rptr_q;
        end else if (wr_ok && IN_VALID) begin
          state_d = WR_SETUP;
          adr_d = wptr_q;
          di_d = IN_DATA;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        we_d = 1'b1;
      end
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD: begin
        state_d = IDLE;
        wptr_d = wptr_q + AW'(1);
        count_d = count_q + CW'(1);
      end
      READ: begin
        state_d = IDLE;
        out_data_d = RAM_O;
        out_valid_d = 1'b1;
        rptr_d = rptr_q + AW'(1);
        count_d = count_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered RAM/stream outputs; reset drops WE at once and forgets any partial write
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      adr_q <= '0;
      di_q <= '0;
      we_q <= 1'b0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      adr_q <= adr_d;
      di_q <= di_d;
      we_q <= we_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  assign RAM_ADR = adr_q;
  assign RAM_I = di_q;
  assign RAM_WE = we_q;
  assign OUT_DATA = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign COUNT = count_q;
  assign FULL = count_q == CW'(DEPTH);
  assign EMPTY = count_q == '0 && !out_valid_q;
endmodule
